// File: rtl/i2s_frame_sequencer_if.sv
// Sample-side bus of the I2S frame sequencer: TX stereo pairs in over a
// valid/ready handshake, RX stereo pairs out as a one-cycle valid pulse.
// master = audio pipeline side, slave = sequencer side.
interface i2s_frame_sequencer_if #(
   parameter int unsigned AUDIO_DW = 16
) ();

   logic                in_valid;
   logic                in_ready;
   logic [AUDIO_DW-1:0] in_left;
   logic [AUDIO_DW-1:0] in_right;
   logic                out_valid;
   logic [AUDIO_DW-1:0] out_left;
   logic [AUDIO_DW-1:0] out_right;

   modport master (
      output in_valid,
      output in_left,
      output in_right,
      input  in_ready,
      input  out_valid,
      input  out_left,
      input  out_right
   );

   modport slave (
      input  in_valid,
      input  in_left,
      input  in_right,
      output in_ready,
      output out_valid,
      output out_left,
      output out_right
   );

endinterface

// File: rtl/i2s_frame_sequencer.sv
// I2S frame sequencer: generates lrclk and the bit-slot counter from sclk,
// serialises staged stereo pairs MSB-first with the one-bit I2S delay and
// deserialises sdata_rx on the same timing. Clean start/stop via IDLE/RUN/TAIL.
// Optional build macro I2S_SEQ_HOLD_LAST_EN: an underrun frame repeats the last
// successfully loaded pair instead of transmitting zeros.
module i2s_frame_sequencer #(
   parameter int unsigned AUDIO_DW = 16,
   parameter int unsigned SLOT_W   = 16
) (
   input  logic                        sclk,
   input  logic                        reset,
   input  logic                        enable,
   i2s_frame_sequencer_if.slave        smp,
   output logic                        lrclk,
   output logic                        sdata_tx,
   input  logic                        sdata_rx,
   output logic                        frame_start,
   output logic                        underrun
);

   localparam int unsigned F     = 2 * SLOT_W;
   localparam int unsigned CNT_W = $clog2(F);
   localparam int unsigned PAD_W = SLOT_W - AUDIO_DW;

   // A slot must be able to hold a full sample
   if (SLOT_W < AUDIO_DW) begin : g_bad_slot_w
      $error("i2s_frame_sequencer: SLOT_W must be >= AUDIO_DW");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_TAIL = 2'd2
   } state_t;

   state_t              state;
   state_t              nxt_state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    nxt_cnt;

   logic                stg_empty;
   logic                nxt_stg_empty;
   logic [AUDIO_DW-1:0] stg_left;
   logic [AUDIO_DW-1:0] stg_right;

   logic [F-1:0]        tx_sr;
   logic [F-2:0]        rx_sr;
   logic [F-1:0]        rx_word;
   logic                rx_active;

   logic                out_valid_q;
   logic [AUDIO_DW-1:0] out_left_q;
   logic [AUDIO_DW-1:0] out_right_q;

   logic                xfer;
   logic                load;
   logic                last_bit;
   logic [AUDIO_DW-1:0] load_left;
   logic [AUDIO_DW-1:0] load_right;
   logic [F-1:0]        frame_word;

`ifdef I2S_SEQ_HOLD_LAST_EN
   logic [AUDIO_DW-1:0] held_left;
   logic [AUDIO_DW-1:0] held_right;
`endif

   assign xfer     = smp.in_valid && stg_empty;
   assign load     = (state == S_RUN) && (bit_cnt == '0);
   assign last_bit = (bit_cnt == CNT_W'(F - 1));
   assign rx_word  = {rx_sr, sdata_rx};

   assign smp.in_ready  = stg_empty;
   assign smp.out_valid = out_valid_q;
   assign smp.out_left  = out_left_q;
   assign smp.out_right = out_right_q;

   // Next state, next slot count and next staging occupancy
   always_comb begin
      nxt_state     = state;
      nxt_cnt       = '0;
      nxt_stg_empty = (stg_empty || load) && !xfer;
      case (state)
         S_IDLE: begin
            if (enable) begin
               nxt_state = S_RUN;
            end
         end
         S_RUN: begin
            if (last_bit) begin
               nxt_state = enable ? S_RUN : S_TAIL;
            end else begin
               nxt_cnt = bit_cnt + CNT_W'(1);
            end
         end
         S_TAIL: begin
            nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
   end

   // Frame word to load: staged pair, or the underrun fill
   always_comb begin
      load_left  = stg_left;
      load_right = stg_right;
      if (stg_empty) begin
`ifdef I2S_SEQ_HOLD_LAST_EN
         load_left  = held_left;
         load_right = held_right;
`else
         load_left  = '0;
         load_right = '0;
`endif
      end
      frame_word = (F'(load_left) << (F - AUDIO_DW)) | (F'(load_right) << PAD_W);
   end

   // Sequencer state, staging, TX/RX shifters and registered pin/status outputs
   always_ff @(posedge sclk) begin
      if (reset) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         stg_empty   <= 1'b1;
         stg_left    <= '0;
         stg_right   <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         rx_active   <= 1'b0;
         lrclk       <= 1'b0;
         sdata_tx    <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         out_valid_q <= 1'b0;
         out_left_q  <= '0;
         out_right_q <= '0;
`ifdef I2S_SEQ_HOLD_LAST_EN
         held_left   <= '0;
         held_right  <= '0;
`endif
      end else begin
         state       <= nxt_state;
         bit_cnt     <= nxt_cnt;
         stg_empty   <= nxt_stg_empty;
         lrclk       <= (nxt_state == S_RUN) && (nxt_cnt >= CNT_W'(SLOT_W));
         frame_start <= (nxt_state == S_RUN) && (nxt_cnt == '0);
         underrun    <= (nxt_state == S_RUN) && (nxt_cnt == '0) && nxt_stg_empty;
         out_valid_q <= 1'b0;

         if (xfer) begin
            stg_left  <= smp.in_left;
            stg_right <= smp.in_right;
         end

         case (state)
            S_RUN: begin
               if (bit_cnt == '0) begin
                  // Frame boundary: load TX word, drive bit 0, close previous RX frame
                  sdata_tx  <= frame_word[F-1];
                  tx_sr     <= {frame_word[F-2:0], 1'b0};
                  rx_active <= 1'b1;
                  if (rx_active) begin
                     out_valid_q <= 1'b1;
                     out_left_q  <= rx_word[F-1 -: AUDIO_DW];
                     out_right_q <= rx_word[SLOT_W-1 -: AUDIO_DW];
                  end
`ifdef I2S_SEQ_HOLD_LAST_EN
                  if (!stg_empty) begin
                     held_left  <= stg_left;
                     held_right <= stg_right;
                  end
`endif
               end else begin
                  sdata_tx <= tx_sr[F-1];
                  tx_sr    <= {tx_sr[F-2:0], 1'b0};
                  rx_sr    <= {rx_sr[F-3:0], sdata_rx};
               end
            end
            S_TAIL: begin
               sdata_tx  <= 1'b0;
               rx_active <= 1'b0;
               if (rx_active) begin
                  out_valid_q <= 1'b1;
                  out_left_q  <= rx_word[F-1 -: AUDIO_DW];
                  out_right_q <= rx_word[SLOT_W-1 -: AUDIO_DW];
               end
            end
            default: begin
               sdata_tx <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
Frame-level controller for the I2S serial link. It generates lrclk and the bit-slot counter from sclk, and accepts stereo sample pairs from upstream over a valid/ready handshake. It sequences them MSB-first onto sdata_tx with the standard one-bit I2S delay, deserialises sdata_rx on the same timing, and handles underrun and clean start/stop. It sits between the audio sample pipeline and the I2S pins, and replaces free-running lrclk generation.

Parameters:
AUDIO_DW, 16, sample width per channel.
SLOT_W, 16, sclk cycles per channel slot; must be >= AUDIO_DW, else elaboration error. Frame length is F = 2*SLOT_W.

Ports:
sclk  input  1  sole clock; all logic on posedge.
reset  input  1  synchronous, active-high.
enable  input  1  run request.
in_valid  input  1  upstream sample pair valid.
in_ready  output  1  staging register empty.
in_left  input  AUDIO_DW  left TX sample.
in_right  input  AUDIO_DW  right TX sample.
lrclk  output  1  0 = left slot, 1 = right slot.
sdata_tx  output  1  serial TX data.
sdata_rx  input  1  serial RX data.
out_valid  output  1  one-cycle pulse, RX pair valid.
out_left  output  AUDIO_DW  received left sample.
out_right  output  AUDIO_DW  received right sample.
frame_start  output  1  one-cycle pulse at bit_cnt==0 in RUN.
underrun  output  1  one-cycle pulse, frame loaded with no staged data.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE, bit_cnt=0 and staging is empty.
  - lrclk, sdata_tx, out_valid, out_left, out_right, frame_start and underrun are all 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-frame aborts immediately; the partial RX frame is discarded.
- Handshake:
  - in_ready = staging empty. A transfer occurs on a posedge with in_valid && in_ready, and staging becomes full.
  - Staging is accepted in any state, including IDLE (pre-load).
  - Staging empties only at a frame load.
- States are IDLE, RUN and TAIL.
  - IDLE -> RUN when enable=1. The first RUN cycle has bit_cnt=0.
  - RUN: bit_cnt increments mod F. At each wrap to 0 (a frame boundary), enable is sampled: if it is 0, go to TAIL instead of starting a new frame.
  - TAIL is exactly one cycle: it emits the final delayed bit, then goes to IDLE.
  - Deasserting enable mid-frame never truncates a frame.
- lrclk in RUN = (bit_cnt >= SLOT_W). lrclk=0 in IDLE and TAIL.
- TX:
  - The frame word is {left, zeros(SLOT_W-AUDIO_DW), right, zeros(SLOT_W-AUDIO_DW)}, with bit j=0 being the left MSB.
  - It loads from staging on every RUN cycle with bit_cnt==0.
  - Bit j is driven in the cycle where bit_cnt==(j+1) mod F, so the final bit lands in bit_cnt 0 of the next frame, or in TAIL.
  - sdata_tx=0 in IDLE, and in the first RUN cycle after IDLE.
- Underrun:
  - If staging is empty at load, underrun pulses in that cycle and the frame word is zeros.
  - If a transfer completes in that same cycle, its data goes to staging for the next frame; it is never bypassed into the current frame.
- RX:
  - sdata_rx is sampled on the posedge ending the cycle bit_cnt==(j+1) mod F, or ending TAIL, into bit j.
  - out_left and out_right take the top AUDIO_DW bits of each slot.
  - out_valid pulses in the cycle after bit F-1 is sampled: bit_cnt==1, or the first IDLE cycle after TAIL.
  - The RX frame started in the first RUN cycle is captured normally.
  - out_left and out_right hold their values between pulses.

Optional Feature:
I2S_SEQ_HOLD_LAST_EN:
- Defined: on underrun, the frame word repeats the last successfully loaded pair instead of zeros. The underrun pulse is unchanged. Reset clears the held pair to zeros.
- Undefined: underrun frames transmit zeros.

Test Plan:
- Reset, in_left=0x4567, in_right=0xCDEF staged, enable=1, sdata_rx looped to sdata_tx -> lrclk low for cycles 0-15 and high for 16-31. First out_valid at bit_cnt==1 of frame 2, with out_left=0x4567 and out_right=0xCDEF.
- Enable with nothing staged -> underrun pulse at bit_cnt==0, sdata_tx=0 for the whole frame. Stage 0x1234/0x5678 mid-frame -> transmitted next frame with no underrun.
- SLOT_W=24, AUDIO_DW=16, loopback 0xA5A5/0x5A5A -> 8 trailing zero bits per slot on sdata_tx, out_left=0xA5A5 and out_right=0x5A5A.
- Deassert enable at bit_cnt==10 -> frame completes, one TAIL cycle carries right LSB, then IDLE (lrclk=0, sdata_tx=0), out_valid pulses in the first IDLE cycle.
- Reset asserted at bit_cnt==20 -> next cycle all outputs 0, in_ready=1, no out_valid; re-enable restarts at bit_cnt=0.
- With I2S_SEQ_HOLD_LAST_EN defined: send 0x4567/0xCDEF, then starve -> underrun pulse and the next frame retransmits 0x4567/0xCDEF.
